ex_ctrl_stage: RTL
==================

EX_CTRL_STAGE -- requirements
Module: ex_ctrl_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: n_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have inputs from decode: RegWriteD 1, ResultSrcD 2, MemWriteD 1, JumpD 1, BranchD 1, ALUSrcAD 2, ALUSrcBD 1, ImmSrcD 3 (not registered), ALUControlD 5, csrD 1, funct3D 3, opcodeD 7.
REQ-004 SHALL have hazard inputs: StallE  input  1  hold E register; FlushE  input  1  load bubble into E.
REQ-005 SHALL have flag inputs: N_flag, Z_flag, C_flag, V_flag  input  1 each  combinational ALU flags of the instruction currently in E.
REQ-006 SHALL have registered outputs: RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE, ALUControlE, csrE, funct3E, opcodeE, and ValidE (1 = real instruction in E).
REQ-007 SHALL have combinational outputs: BtakenE 1; PCSrcE 2 (00 PC+4, 01 PC+ImmExtE, 10 ALUResultE); RedirectE 1 (PCSrcE != 00), which drives the D and E flush.

Function
REQ-008 SHALL capture all D-stage control fields into the E register on each rising edge when not stalled and not flushed, latency exactly one cycle.
REQ-009 SHALL define a bubble as: all registered outputs zero, including ValidE=0 and opcodeE=0.
REQ-010 SHALL compute the effective flush as FlushE OR RedirectE; an effective flush loads a bubble on the next edge.
REQ-011 SHALL apply priority n_rst > effective flush > StallE > normal load; StallE holds every E field unchanged.
REQ-012 SHALL compute BtakenE from funct3E when BranchE=1 and ValidE=1: 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 !C; 111 C; 010/011 0.
REQ-013 SHALL force BtakenE=0 when BranchE=0 or ValidE=0.
REQ-014 SHALL drive PCSrcE=10 when JumpE=1, ValidE=1 and opcodeE=1100111 (JALR).
REQ-015 SHALL drive PCSrcE=01 when JumpE=1 with any other opcodeE (JAL), or when BtakenE=1.
REQ-016 SHALL drive PCSrcE=00 otherwise, including whenever ValidE=0.
REQ-017 SHALL not suppress RedirectE when StallE=1; a stalled taken branch keeps redirecting until E advances.
REQ-018 SHALL ensure a redirecting instruction is replaced by a bubble on the following edge (self-flush), so RedirectE asserts for exactly one cycle per instruction absent stall.

Reset
REQ-019 SHALL set all registered outputs to zero asynchronously while n_rst=0, which makes ValidE=0, PCSrcE=00 and BtakenE=0.
REQ-020 SHALL resume normal loading on the first rising edge after n_rst deasserts; reset mid-redirect discards the redirect.

Structure
REQ-021 SHALL take the PCSrc encodings, opcode constants (JALR 1100111, BRANCH 1100011, JAL 1101111, SYSTEM 1110011) and branch funct3 codes from a shared package pipe_pkg.
REQ-022 SHALL place flag-to-BtakenE evaluation in one sub-module branch_cond (inputs funct3, flags, Branch, Valid; output Btaken), purely combinational.
REQ-023 SHALL keep the E register and PCSrcE selection in ex_ctrl_stage and contain no other state.

Verification
REQ-024 SHALL verify: BEQ loaded (BranchD=1, funct3D=000), next cycle Z_flag=1 -> BtakenE=1, PCSrcE=01, RedirectE=1; following cycle ValidE=0.
REQ-025 SHALL verify: BLTU with C_flag=1 -> BtakenE=0, PCSrcE=00; with C_flag=0 -> PCSrcE=01.
REQ-026 SHALL verify: JALR (opcodeD=1100111, JumpD=1) -> PCSrcE=10 for one cycle, then bubble, regardless of D inputs.
REQ-027 SHALL verify: StallE=1 for 3 cycles with ADD in E (RegWriteE=1, ALUControlE=00000) -> all E fields unchanged; FlushE=1 with StallE=1 -> bubble.
REQ-028 SHALL verify: n_rst pulled low mid-cycle while BNE taken in E -> outputs zero immediately, PCSrcE=00 with no clock edge.
REQ-029 SHALL verify: funct3E=010 with BranchE=1 and all flags 1 -> BtakenE=0, PCSrcE=00.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: PC source select, opcodes, branch funct3 codes
// and the packed E-stage control record.
package pipe_pkg;

  typedef enum logic [1:0] {
    PcSrcPlus4 = 2'b00,
    PcSrcImm   = 2'b01,
    PcSrcAlu   = 2'b10
  } pc_src_e;

  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic [4:0] alu_control;
    logic       csr;
    logic [2:0] funct3;
    logic [6:0] opcode;
  } ex_ctrl_t;

  localparam ex_ctrl_t ExBubble = '0;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluation from the ALU flags of the
// instruction in E.
module branch_cond
  import pipe_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       n_flag_i,
  input  logic       z_flag_i,
  input  logic       c_flag_i,
  input  logic       v_flag_i,
  input  logic       branch_i,
  input  logic       valid_i,
  output logic       btaken_o
);

  always_comb begin
    btaken_o = 1'b0;
    if (branch_i && valid_i) begin
      // C is the no-borrow flag of a - b, so unsigned less-than is !C
      case (funct3_i)
        F3Beq:   btaken_o = z_flag_i;
        F3Bne:   btaken_o = !z_flag_i;
        F3Blt:   btaken_o = n_flag_i ^ v_flag_i;
        F3Bge:   btaken_o = !(n_flag_i ^ v_flag_i);
        F3Bltu:  btaken_o = !c_flag_i;
        F3Bgeu:  btaken_o = c_flag_i;
        default: btaken_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ex_ctrl_stage.sv
// D->E control pipeline register with branch/jump resolution; a redirecting
// instruction flushes itself so the redirect lasts one cycle.
module ex_ctrl_stage
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       RegWriteD,
  input  logic [1:0] ResultSrcD,
  input  logic       MemWriteD,
  input  logic       JumpD,
  input  logic       BranchD,
  input  logic [1:0] ALUSrcAD,
  input  logic       ALUSrcBD,
  input  logic [2:0] ImmSrcD,
  input  logic [4:0] ALUControlD,
  input  logic       csrD,
  input  logic [2:0] funct3D,
  input  logic [6:0] opcodeD,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic       N_flag,
  input  logic       Z_flag,
  input  logic       C_flag,
  input  logic       V_flag,
  output logic       RegWriteE,
  output logic [1:0] ResultSrcE,
  output logic       MemWriteE,
  output logic       JumpE,
  output logic       BranchE,
  output logic [1:0] ALUSrcAE,
  output logic       ALUSrcBE,
  output logic [4:0] ALUControlE,
  output logic       csrE,
  output logic [2:0] funct3E,
  output logic [6:0] opcodeE,
  output logic       ValidE,
  output logic       BtakenE,
  output logic [1:0] PCSrcE,
  output logic       RedirectE
);

  ex_ctrl_t e_q, e_d;
  pc_src_e  pc_src;
  logic     unused_imm_src;

  // Immediate select is consumed in D; it never enters the E register
  assign unused_imm_src = ^ImmSrcD;

  always_comb begin
    e_d = e_q;
    if (FlushE || RedirectE) begin
      e_d = ExBubble;
    end else if (!StallE) begin
      e_d.valid       = 1'b1;
      e_d.reg_write   = RegWriteD;
      e_d.result_src  = ResultSrcD;
      e_d.mem_write   = MemWriteD;
      e_d.jump        = JumpD;
      e_d.branch      = BranchD;
      e_d.alu_src_a   = ALUSrcAD;
      e_d.alu_src_b   = ALUSrcBD;
      e_d.alu_control = ALUControlD;
      e_d.csr         = csrD;
      e_d.funct3      = funct3D;
      e_d.opcode      = opcodeD;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      e_q <= ExBubble;
    end else begin
      e_q <= e_d;
    end
  end

  branch_cond u_branch_cond (
    .funct3_i (e_q.funct3),
    .n_flag_i (N_flag),
    .z_flag_i (Z_flag),
    .c_flag_i (C_flag),
    .v_flag_i (V_flag),
    .branch_i (e_q.branch),
    .valid_i  (e_q.valid),
    .btaken_o (BtakenE)
  );

  always_comb begin
    pc_src = PcSrcPlus4;
    if (e_q.valid && e_q.jump) begin
      pc_src = (e_q.opcode == OpcJalr) ? PcSrcAlu : PcSrcImm;
    end else if (BtakenE) begin
      pc_src = PcSrcImm;
    end
  end

  assign PCSrcE      = pc_src;
  assign RedirectE   = (pc_src != PcSrcPlus4);

  assign ValidE      = e_q.valid;
  assign RegWriteE   = e_q.reg_write;
  assign ResultSrcE  = e_q.result_src;
  assign MemWriteE   = e_q.mem_write;
  assign JumpE       = e_q.jump;
  assign BranchE     = e_q.branch;
  assign ALUSrcAE    = e_q.alu_src_a;
  assign ALUSrcBE    = e_q.alu_src_b;
  assign ALUControlE = e_q.alu_control;
  assign csrE        = e_q.csr;
  assign funct3E     = e_q.funct3;
  assign opcodeE     = e_q.opcode;

endmodule
